// File: rtl/seg_mux_pkg.sv
// seg_mux_pkg: shared state encoding and counter sizing for the display multiplex scheduler.
package seg_mux_pkg;

    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} mux_state_t;

    // Dwell counter must hold the longer of the two dwell lengths; never narrower than one bit.
    function automatic int cnt_width(int refresh, int blank);
        int longest;
        longest = refresh > blank ? refresh : blank;
        return longest <= 1 ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts 0..term, flags the last cycle and wraps to zero there.
module dwell_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         done
);

    assign done = cnt == term;

    always_ff @(posedge clk) begin
        if (!reset || done)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seg_mux_scheduler.sv
// seg_mux_scheduler: alternates two digits through one shared decoder with blanking gaps;
// new digit values are staged and committed together at the frame boundary.
module seg_mux_scheduler
    import seg_mux_pkg::*;
#(
    parameter int REFRESH_CYCLES = 4096,
    parameter int BLANK_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic       upd,
    output logic [3:0] s_sel,
    output logic       en0_n,
    output logic       en1_n,
    output logic       frame_start
);

    localparam int W = cnt_width(REFRESH_CYCLES, BLANK_CYCLES);
    localparam logic [W-1:0] SHOW_LAST  = W'(REFRESH_CYCLES - 1);
    localparam logic [W-1:0] BLANK_LAST = W'(BLANK_CYCLES - 1);

    mux_state_t state, next;
    logic [W-1:0] cnt;
    logic         done;
    logic         commit;
    logic         show;
    logic [3:0]   shadow0, shadow1, pend0, pend1;
    logic         pend_v;

    assign show   = state == SHOW0 || state == SHOW1;
    assign next   = state == BLANK0 ? SHOW0 : state == SHOW0 ? BLANK1 : state == BLANK1 ? SHOW1 : BLANK0;
    assign commit = done && state == SHOW1;

    dwell_counter #(.W(W)) u_dwell (
        .clk  (clk),
        .reset(reset),
        .term (show ? SHOW_LAST : BLANK_LAST),
        .cnt  (cnt),
        .done (done)
    );

    // An update landing on the commit edge bypasses the pending stage so it shows next frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= BLANK0;
            shadow0 <= '0;
            shadow1 <= '0;
            pend0   <= '0;
            pend1   <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (done)
                state <= next;
            if (upd) begin
                pend0 <= s0;
                pend1 <= s1;
            end
            pend_v <= !commit && (upd || pend_v);
            if (commit && (upd || pend_v)) begin
                shadow0 <= upd ? s0 : pend0;
                shadow1 <= upd ? s1 : pend1;
            end
        end
    end

    assign en0_n       = state != SHOW0;
    assign en1_n       = state != SHOW1;
    assign s_sel       = (state == BLANK0 || state == SHOW0) ? shadow0 : shadow1;
    assign frame_start = state == BLANK0 && cnt == '0;

endmodule
